// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, line-state encoding and colour-bar constants for the
// LCD pixel reader and its raster counter.
package lcd_timing_pkg;

  localparam int unsigned H_TOTAL_DEF  = 1056;
  localparam int unsigned V_TOTAL_DEF  = 525;
  localparam int unsigned H_START_DEF  = 216;
  localparam int unsigned V_START_DEF  = 35;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned H_SYNC_W_DEF = 1;
  localparam int unsigned V_SYNC_W_DEF = 1;

  localparam int unsigned H_W = 11;
  localparam int unsigned V_W = 10;

  typedef enum logic [1:0] {
    HSYNC,
    BPORCH,
    ACTIVE,
    FPORCH
  } line_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFF_FF_00;
  localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
  localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
  localparam logic [23:0] BAR_BLUE    = 24'h00_00_FF;
  localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/lcd_raster_counter.sv
// Horizontal/vertical raster counters and the line-phase FSM. Exposes the
// next-slot values so the top can register outputs aligned with the counters.
module lcd_raster_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned H_START  = H_START_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC_W = H_SYNC_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           en,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic [H_W-1:0] h_nxt,
  output logic [V_W-1:0] v_nxt,
  output line_state_e    state_nxt,
  output logic           load
);

  localparam logic [H_W-1:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_SYNC_E  = 11'(H_SYNC_W);
  localparam logic [H_W-1:0] H_ACT_B   = 11'(H_START);
  localparam logic [H_W-1:0] H_ACT_E   = 11'(H_START + H_ACTIVE);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  line_state_e    state_q, state_d;
  logic           run_q, run_d;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    state_d = state_q;
    run_d   = run_q;
    load    = 1'b0;
    if (!en) begin
      h_d     = '0;
      v_d     = '0;
      state_d = HSYNC;
      run_d   = 1'b0;
    end else if (ce) begin
      load  = 1'b1;
      run_d = 1'b1;
      // The first slot after Enable rises shows 0,0 itself rather than stepping past it.
      if (run_q) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 11'd1;
        end
      end
      case (state_q)
        HSYNC:   if (h_d >= H_SYNC_E) state_d = BPORCH;
        BPORCH:  if (h_d >= H_ACT_B)  state_d = ACTIVE;
        ACTIVE:  if (h_d >= H_ACT_E)  state_d = FPORCH;
        FPORCH:  if (h_d == '0)       state_d = HSYNC;
        default: state_d = HSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= HSYNC;
      run_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  assign h_nxt     = h_d;
  assign v_nxt     = v_d;
  assign state_nxt = state_d;

endmodule

// File: rtl/lcd_pixel_reader.sv
// LCD panel driver reading the filter output buffer: request window, RAM-latency
// alignment and sync generation. Optional colour bars: LCD_PIXEL_READER_TEST_PATTERN_EN.
module lcd_pixel_reader
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned H_START  = H_START_DEF,
  parameter int unsigned V_START  = V_START_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned H_SYNC_W = H_SYNC_W_DEF,
  parameter int unsigned V_SYNC_W = V_SYNC_W_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Clock_en,
  input  logic        Enable,
`ifdef LCD_PIXEL_READER_TEST_PATTERN_EN
  input  logic        Pattern_sel,
`endif
  output logic [10:0] H_Count,
  output logic [9:0]  V_Count,
  output logic        oRead_out_en,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
  output logic [7:0]  LCD_R,
  output logic [7:0]  LCD_G,
  output logic [7:0]  LCD_B,
  output logic        LCD_DEN,
  output logic        LCD_HSYNC_n,
  output logic        LCD_VSYNC_n,
  output logic        Frame_start
);

  // Requests lead display by two slots: one for the RAM register, one for capture.
  localparam logic [H_W-1:0] RD_FIRST = 11'(H_START - 2);
  localparam logic [H_W-1:0] RD_LAST  = 11'(H_START + H_ACTIVE - 3);
  localparam logic [V_W-1:0] V_FIRST  = 10'(V_START);
  localparam logic [V_W-1:0] V_END    = 10'(V_START + V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_E = 10'(V_SYNC_W);

  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  line_state_e    state_nxt;
  logic           load;

  lcd_raster_counter #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .H_START  (H_START),
    .H_ACTIVE (H_ACTIVE),
    .H_SYNC_W (H_SYNC_W)
  ) u_raster (
    .clk       (Clock),
    .rst       (Reset),
    .ce        (Clock_en),
    .en        (Enable),
    .h_cnt     (H_Count),
    .v_cnt     (V_Count),
    .h_nxt     (h_nxt),
    .v_nxt     (v_nxt),
    .state_nxt (state_nxt),
    .load      (load)
  );

  logic        rd_q, rd_d;
  logic [23:0] rgb_q, rgb_d;
  logic        den_q, den_d;
  logic        hs_n_q, hs_n_d;
  logic        vs_n_q, vs_n_d;
  logic        fs_q, fs_d;
  logic        act_line;
  logic [23:0] src_rgb;

`ifdef LCD_PIXEL_READER_TEST_PATTERN_EN
  localparam logic [H_W-1:0] H_ACT_B = 11'(H_START);
  localparam logic [H_W-1:0] BAR_W   = 11'(H_ACTIVE / 8);
  logic [H_W-1:0] pix_x;
  logic [2:0]     bar_idx;

  always_comb begin
    pix_x   = h_nxt - H_ACT_B;
    bar_idx = 3'(pix_x / BAR_W);
    src_rgb = Pattern_sel ? bar_rgb(bar_idx) : {R_in, G_in, B_in};
  end
`else
  assign src_rgb = {R_in, G_in, B_in};
`endif

  assign act_line = (v_nxt >= V_FIRST) && (v_nxt < V_END);

  always_comb begin
    rd_d   = rd_q;
    rgb_d  = rgb_q;
    den_d  = den_q;
    hs_n_d = hs_n_q;
    vs_n_d = vs_n_q;
    fs_d   = 1'b0;
    if (!Enable) begin
      rd_d   = 1'b0;
      rgb_d  = '0;
      den_d  = 1'b0;
      hs_n_d = 1'b1;
      vs_n_d = 1'b1;
    end else if (load) begin
      rd_d   = act_line && (h_nxt >= RD_FIRST) && (h_nxt <= RD_LAST);
      den_d  = act_line && (state_nxt == ACTIVE);
      rgb_d  = den_d ? src_rgb : '0;
      hs_n_d = (state_nxt != HSYNC);
      vs_n_d = (v_nxt >= V_SYNC_E);
      fs_d   = (h_nxt == '0) && (v_nxt == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_q   <= 1'b0;
      rgb_q  <= '0;
      den_q  <= 1'b0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      rgb_q  <= rgb_d;
      den_q  <= den_d;
      hs_n_q <= hs_n_d;
      vs_n_q <= vs_n_d;
      fs_q   <= fs_d;
    end
  end

  assign oRead_out_en = rd_q;
  assign LCD_R        = rgb_q[23:16];
  assign LCD_G        = rgb_q[15:8];
  assign LCD_B        = rgb_q[7:0];
  assign LCD_DEN      = den_q;
  assign LCD_HSYNC_n  = hs_n_q;
  assign LCD_VSYNC_n  = vs_n_q;
  assign Frame_start  = fs_q;

endmodule

// File: tb/tb_lcd_pixel_reader.sv
// Directed bench for lcd_pixel_reader on a reduced raster (40x12 slots) with a
// registered line-buffer model feeding R/G/B_in.
module tb_lcd_pixel_reader;

  localparam int unsigned HT  = 40;
  localparam int unsigned VT  = 12;
  localparam int unsigned HS  = 8;
  localparam int unsigned VS  = 3;
  localparam int unsigned HA  = 24;
  localparam int unsigned VA  = 6;
  localparam int unsigned HSW = 2;
  localparam int unsigned VSW = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Clock_en = 1'b0;
  logic        Enable = 1'b0;
  logic [7:0]  R_in = '0, G_in = '0, B_in = '0;
  logic [10:0] H_Count;
  logic [9:0]  V_Count;
  logic        oRead_out_en;
  logic [7:0]  LCD_R, LCD_G, LCD_B;
  logic        LCD_DEN, LCD_HSYNC_n, LCD_VSYNC_n, Frame_start;
  logic        pat_mode = 1'b0;
`ifdef LCD_PIXEL_READER_TEST_PATTERN_EN
  logic        Pattern_sel;
  assign Pattern_sel = pat_mode;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned idx = 0;
  int unsigned rd_cnt, hs_cnt, vs_cnt, fs_cnt, line_rd;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  lcd_pixel_reader #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_SYNC_W(HSW), .V_SYNC_W(VSW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Clock_en(Clock_en), .Enable(Enable),
`ifdef LCD_PIXEL_READER_TEST_PATTERN_EN
    .Pattern_sel(Pattern_sel),
`endif
    .H_Count(H_Count), .V_Count(V_Count), .oRead_out_en(oRead_out_en),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .LCD_DEN(LCD_DEN),
    .LCD_HSYNC_n(LCD_HSYNC_n), .LCD_VSYNC_n(LCD_VSYNC_n), .Frame_start(Frame_start)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    @(posedge Clock);
    #2;
    Clock_en = ~Clock_en;
  end

  // Buffer model: q_b registers the next word on each granted slot; address clears while idle.
  initial begin : buf_model
    logic fire;
    forever begin
      @(negedge Clock);
      fire = Clock_en && oRead_out_en;
      @(posedge Clock);
      #1;
      if (!Enable) idx = 0;
      else if (fire) begin
        R_in = idx[7:0];
        G_in = ~idx[7:0];
        B_in = idx[7:0] ^ 8'h5A;
        idx++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (H=%0d V=%0d)", tag, obs, exp, H_Count, V_Count);
    end
  endtask

  task automatic next_slot();
    logic ce;
    int unsigned n;
    n = 0;
    do begin
      ce = Clock_en;
      @(posedge Clock);
      #3;
      n++;
    end while (!ce && n < 4);
    @(negedge Clock);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_h"}, H_Count, 0);
    chk({tag, "_v"}, V_Count, 0);
    chk({tag, "_rd"}, oRead_out_en, 0);
    chk({tag, "_den"}, LCD_DEN, 0);
    chk({tag, "_rgb"}, {LCD_R, LCD_G, LCD_B}, 0);
    chk({tag, "_hs_n"}, LCD_HSYNC_n, 1);
    chk({tag, "_vs_n"}, LCD_VSYNC_n, 1);
  endtask

  task automatic check_slot(input int unsigned h, input int unsigned v, input int unsigned base);
    logic act, rd_e, den_e;
    logic [23:0] rgb_e;
    int unsigned k;
    act   = (v >= VS) && (v < VS + VA);
    rd_e  = act && (h >= HS - 2) && (h <= HS + HA - 3);
    den_e = act && (h >= HS) && (h < HS + HA);
    rgb_e = '0;
    if (den_e) begin
      if (pat_mode) rgb_e = bars[(h - HS) / (HA / 8)];
      else begin
        k = base + (v - VS) * HA + (h - HS);
        rgb_e = {k[7:0], ~k[7:0], k[7:0] ^ 8'h5A};
      end
    end
    chk("h_count", H_Count, h);
    chk("v_count", V_Count, v);
    chk("read_en", oRead_out_en, rd_e);
    chk("den", LCD_DEN, den_e);
    chk("rgb", {LCD_R, LCD_G, LCD_B}, rgb_e);
    chk("hsync_n", LCD_HSYNC_n, h >= HSW);
    chk("vsync_n", LCD_VSYNC_n, v >= VSW);
    chk("frame_start", Frame_start, (h == 0) && (v == 0));
    rd_cnt  += oRead_out_en;
    line_rd += oRead_out_en;
    hs_cnt  += !LCD_HSYNC_n;
    vs_cnt  += !LCD_VSYNC_n;
    fs_cnt  += Frame_start;
    if (h == HT - 1) begin
      chk("line_requests", line_rd, act ? HA : 0);
      line_rd = 0;
    end
  endtask

  task automatic clear_tallies();
    rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; line_rd = 0;
  endtask

  task automatic check_tallies();
    chk("frame_requests", rd_cnt, HA * VA);
    chk("hsync_slots", hs_cnt, HSW * VT);
    chk("vsync_slots", vs_cnt, VSW * HT);
    chk("frame_pulses", fs_cnt, 1);
  endtask

  initial begin
    // Reset dominates a raised Enable
    Reset = 1'b1;
    Enable = 1'b1;
    repeat (6) @(negedge Clock);
    check_idle("reset");
    chk("reset_fs", Frame_start, 0);

    Reset = 1'b0;
    Enable = 1'b0;
    repeat (4) @(negedge Clock);
    check_idle("idle");

    // Frame 1 from a fresh start
    Enable = 1'b1;
    clear_tallies();
    for (int unsigned s = 0; s < HT * VT; s++) begin
      next_slot();
      check_slot(s % HT, s / HT, 0);
      if (s == 0) begin
        @(posedge Clock);
        @(negedge Clock);
        chk("fs_selfclear", Frame_start, 0);
        chk("hold_h", H_Count, 0);
        chk("hold_hs_n", LCD_HSYNC_n, 0);
      end
    end
    check_tallies();

    // Wrap into frame 2, run to H=20,V=4, then drop Enable
    for (int unsigned s = 0; s <= 4 * HT + 20; s++) begin
      next_slot();
      check_slot(s % HT, s / HT, HA * VA);
    end
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check_idle("drop");
    repeat (10) @(negedge Clock);
    check_idle("drop_hold");
    chk("drop_fs", Frame_start, 0);

    // Restart (colour bars when the pattern build is selected)
`ifdef LCD_PIXEL_READER_TEST_PATTERN_EN
    pat_mode = 1'b1;
`endif
    Enable = 1'b1;
    clear_tallies();
    for (int unsigned s = 0; s < HT * VT; s++) begin
      next_slot();
      check_slot(s % HT, s / HT, 0);
    end
    check_tallies();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
